// File: rtl/fwd_hazard_if.sv
// Decode-side bundle between the pipeline and the forwarding/stall unit.
// The pipeline is master; the hazard unit is slave.
interface fwd_hazard_if #(
    parameter int NUM_RD = 2,
    parameter int DEPTH  = 3,
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int TW     = $clog2(DEPTH + 1)
);
    logic                   issue_valid;
    logic                   issue_we;
    logic [AW-1:0]          issue_waddr;
    logic [TW-1:0]          issue_tnew;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*TW-1:0]   rd_tuse;
    logic [NUM_RD*DW-1:0]   rd_gdata;
    logic [DEPTH*DW-1:0]    stage_data;
    logic                   flush;
    logic                   stall;
    logic [NUM_RD*DW-1:0]   rd_fwd_data;
    logic [NUM_RD-1:0]      rd_fwd_hit;
    logic [15:0]            perf_stall_cnt;

    modport master (
        output issue_valid, issue_we, issue_waddr, issue_tnew,
        output rd_addr, rd_tuse, rd_gdata, stage_data, flush,
        input  stall, rd_fwd_data, rd_fwd_hit, perf_stall_cnt
    );

    modport slave (
        input  issue_valid, issue_we, issue_waddr, issue_tnew,
        input  rd_addr, rd_tuse, rd_gdata, stage_data, flush,
        output stall, rd_fwd_data, rd_fwd_hit, perf_stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Scoreboard-based operand forwarding and decode stall unit.
// Entry 0 is E, entry DEPTH-1 is W; tnew counts down as entries shift.
module fwd_hazard_unit #(
    parameter int NUM_RD = 2,
    parameter int DEPTH  = 3,
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int TW     = $clog2(DEPTH + 1)
) (
    input logic        clk,
    input logic        reset,
    fwd_hazard_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic          valid;
        logic          we;
        logic [AW-1:0] waddr;
        logic [TW-1:0] tnew;
    } sb_entry_t;

    sb_entry_t           sb_q [DEPTH];
    logic [15:0]         perf_q;
    logic [NUM_RD-1:0]   m_found;
    logic [IW-1:0]       m_idx [NUM_RD];
    logic [NUM_RD-1:0]   port_stall;
    logic [NUM_RD-1:0]   hit_c;
    logic [NUM_RD*DW-1:0] data_c;
    logic                stall_c;
    logic [TW-1:0]       tnew_sat;

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        m_found = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            m_idx[k] = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (sb_q[i].valid && sb_q[i].we &&
                    sb_q[i].waddr == bus.rd_addr[k*AW +: AW] &&
                    sb_q[i].waddr != '0) begin
                    m_found[k] = 1'b1;
                    m_idx[k]   = IW'(i);
                end
            end
        end
    end

    always_comb begin
        data_c     = bus.rd_gdata;
        hit_c      = '0;
        port_stall = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (m_found[k]) begin
                if (sb_q[m_idx[k]].tnew == '0) begin
                    data_c[k*DW +: DW] =
                        bus.stage_data[int'(m_idx[k])*DW +: DW];
                    hit_c[k] = 1'b1;
                end
                if (sb_q[m_idx[k]].tnew > bus.rd_tuse[k*TW +: TW])
                    port_stall[k] = 1'b1;
            end
        end
    end

    assign stall_c  = bus.issue_valid && (|port_stall);
    assign tnew_sat = (bus.issue_tnew > TW'(DEPTH - 1)) ?
                      TW'(DEPTH - 1) : bus.issue_tnew;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                sb_q[i] <= '0;
            perf_q <= '0;
        end else begin
            if (stall_c && perf_q != 16'hFFFF)
                perf_q <= perf_q + 16'd1;
            if (bus.flush) begin
                for (int i = 0; i < DEPTH; i++)
                    sb_q[i] <= '0;
            end else begin
                // A stalled issue enters E as a bubble.
                if (bus.issue_valid && !stall_c)
                    sb_q[0] <= '{1'b1, bus.issue_we,
                                 bus.issue_waddr, tnew_sat};
                else
                    sb_q[0] <= '0;
                for (int i = 1; i < DEPTH; i++) begin
                    sb_q[i]      <= sb_q[i-1];
                    sb_q[i].tnew <= (sb_q[i-1].tnew != '0) ?
                                    sb_q[i-1].tnew - TW'(1) : '0;
                end
            end
        end
    end

    assign bus.stall          = stall_c;
    assign bus.rd_fwd_data    = data_c;
    assign bus.rd_fwd_hit     = hit_c;
    assign bus.perf_stall_cnt = perf_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit against an age-based in-flight model.
// Stimulus pushes expectations; a monitor pops and compares each cycle.
module tb_fwd_hazard_unit;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 3;
    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int TW     = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    fwd_hazard_if #(.NUM_RD(NUM_RD), .DEPTH(DEPTH), .DW(DW),
                    .AW(AW), .TW(TW)) bus ();

    fwd_hazard_unit #(.NUM_RD(NUM_RD), .DEPTH(DEPTH), .DW(DW),
                      .AW(AW), .TW(TW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        bit we;
        int waddr;
        int tnew;
        int age;
    } rec_t;

    typedef struct {
        bit                   stall;
        bit [NUM_RD-1:0]      hit;
        bit [NUM_RD*DW-1:0]   data;
        bit [15:0]            cnt;
    } exp_t;

    rec_t infl[$];
    exp_t exp_q[$];
    int   model_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;

    // Expected outputs from in-flight records: an instruction of age a
    // has max(0, tnew - a) stages left and sits in stage a.
    task automatic predict(output exp_t e);
        bit any_stall;
        e.data = bus.rd_gdata;
        e.hit = '0;
        any_stall = 0;
        for (int k = 0; k < NUM_RD; k++) begin
            int ra;
            int best;
            ra = int'(bus.rd_addr[k*AW +: AW]);
            best = -1;
            foreach (infl[j])
                if (infl[j].we && infl[j].waddr == ra && ra != 0 &&
                    (best < 0 || infl[j].age < infl[best].age))
                    best = j;
            if (best >= 0) begin
                int rem;
                rem = infl[best].tnew - infl[best].age;
                if (rem < 0) rem = 0;
                if (rem == 0) begin
                    e.data[k*DW +: DW] =
                        bus.stage_data[infl[best].age*DW +: DW];
                    e.hit[k] = 1'b1;
                end
                if (rem > int'(bus.rd_tuse[k*TW +: TW]))
                    any_stall = 1;
            end
        end
        e.stall = bus.issue_valid && any_stall;
        e.cnt = 16'(model_cnt);
    endtask

    task automatic drive_cycle(input bit rst, input bit iv, input bit we,
                               input int wa, input int tn, input bit fl,
                               input int ra0, input int ra1,
                               input int tu0, input int tu1);
        exp_t e;
        rec_t r;
        rec_t nxt[$];
        reset = rst;
        bus.issue_valid = iv;
        bus.issue_we = we;
        bus.issue_waddr = AW'(wa);
        bus.issue_tnew = TW'(tn);
        bus.flush = fl;
        bus.rd_addr = {AW'(ra1), AW'(ra0)};
        bus.rd_tuse = {TW'(tu1), TW'(tu0)};
        bus.rd_gdata = {$urandom, $urandom};
        bus.stage_data = {$urandom, $urandom, $urandom};
        if (!rst) begin
            infl.delete();
            model_cnt = 0;
        end
        predict(e);
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            if (e.stall && model_cnt < 65535)
                model_cnt++;
            if (fl) begin
                infl.delete();
            end else begin
                foreach (infl[j])
                    if (infl[j].age + 1 < DEPTH) begin
                        r = infl[j];
                        r.age++;
                        nxt.push_back(r);
                    end
                if (iv && !e.stall) begin
                    r.we = we;
                    r.waddr = wa;
                    r.tnew = (tn > DEPTH - 1) ? DEPTH - 1 : tn;
                    r.age = 0;
                    nxt.push_back(r);
                end
                infl = nxt;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (bus.stall !== e.stall || bus.rd_fwd_hit !== e.hit ||
                    bus.rd_fwd_data !== e.data ||
                    bus.perf_stall_cnt !== e.cnt) begin
                    n_err++;
                    $display("FAIL vec%0d: stall %0b want %0b, hit %b want %b, data %h want %h, cnt %0d want %0d",
                             n_vec, bus.stall, e.stall, bus.rd_fwd_hit,
                             e.hit, bus.rd_fwd_data, e.data,
                             bus.perf_stall_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.issue_valid = 0;
        bus.issue_we = 0;
        bus.issue_waddr = '0;
        bus.issue_tnew = '0;
        bus.flush = 0;
        bus.rd_addr = '0;
        bus.rd_tuse = '0;
        bus.rd_gdata = '0;
        bus.stage_data = '0;
        @(negedge clk);
        // reset held: issue ignored, reads pass through
        drive_cycle(0, 1, 1, 9, 0, 0, 9, 9, 0, 0);
        drive_cycle(0, 1, 1, 9, 0, 0, 9, 9, 0, 0);
        // add $9 then beq reading $9
        drive_cycle(1, 1, 1, 9, 1, 0, 0, 0, 0, 0);
        drive_cycle(1, 1, 0, 0, 0, 0, 9, 0, 0, 0);
        drive_cycle(1, 1, 0, 0, 0, 0, 9, 0, 0, 0);
        // lw $10 then consumer with tuse 1
        drive_cycle(1, 1, 1, 10, 2, 0, 0, 0, 0, 0);
        drive_cycle(1, 1, 0, 0, 0, 0, 0, 10, 0, 1);
        drive_cycle(1, 1, 0, 0, 0, 0, 0, 10, 0, 1);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 10, 0, 1);
        // write to $0 never forwards or stalls
        drive_cycle(1, 1, 1, 0, 2, 0, 0, 0, 0, 0);
        drive_cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // two $11 producers, both ports read $11
        drive_cycle(1, 1, 1, 11, 0, 0, 0, 0, 0, 0);
        drive_cycle(1, 1, 1, 11, 0, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 11, 11, 0, 0);
        // saturated tnew, stall coincident with flush
        drive_cycle(1, 1, 1, 12, 3, 0, 0, 0, 0, 0);
        drive_cycle(1, 1, 0, 0, 0, 1, 12, 12, 0, 0);
        drive_cycle(1, 1, 0, 0, 0, 0, 12, 12, 0, 0);
        // reset asserted mid-stall
        drive_cycle(1, 1, 1, 9, 2, 0, 0, 0, 0, 0);
        drive_cycle(1, 1, 0, 0, 0, 0, 9, 0, 0, 0);
        drive_cycle(0, 1, 0, 0, 0, 0, 9, 0, 0, 0);
        drive_cycle(1, 1, 0, 0, 0, 0, 9, 0, 0, 0);
        repeat (600) begin
            drive_cycle(1, $urandom_range(0, 3) != 0,
                        1'($urandom_range(0, 1)),
                        $urandom_range(0, 4), $urandom_range(0, 3),
                        $urandom_range(0, 24) == 0,
                        $urandom_range(0, 4), $urandom_range(0, 4),
                        $urandom_range(0, 3), $urandom_range(0, 3));
        end
        @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
